product_accumulator: RTL and testbench

Sequential accumulation stage directly downstream of the `Multiplier` unit in the systolic-array datapath. Consumes a stream of unsigned `2*WORD_WIDTH`-bit products via valid/ready, sums them over a group terminated by a `last` flag, and presents the group total and beat count on a held output handshake. Forms the accumulate half of a PE's multiply-accumulate path and the drain point for partial sums.

---
 rtl/acc_pkg.sv | 16 +
 rtl/acc_adder.sv | 29 ++
 rtl/product_accumulator.sv | 132 +++++++++++++
 tb/tb_product_accumulator.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// acc_pkg: shared definitions for the product accumulation stage.
//   - acc_state_e : accumulator FSM states (IDLE, ACCUM, HOLD)
//   - DEF_*       : default width constants used by product_accumulator
package acc_pkg;

    localparam int DEF_WORD_WIDTH  = 8;
    localparam int DEF_ACC_WIDTH   = 32;
    localparam int DEF_COUNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no beats taken in the current group
        ACCUM = 2'd1,   // at least one beat taken, no last yet
        HOLD  = 2'd2    // group result presented on the output
    } acc_state_e;

endpackage

// File: rtl/acc_adder.sv
// acc_adder: combinational unsigned ACC_WIDTH-bit adder.
//   a, b  : operands
//   sum   : a+b, wrapped modulo 2^ACC_WIDTH, or clamped to all-ones on
//           carry-out when PRODUCT_ACC_SATURATE_EN is defined
//   carry : carry out of the ACC_WIDTH-bit add
// Build option: PRODUCT_ACC_SATURATE_EN (clamp instead of wrap).
module acc_adder #(
    parameter int ACC_WIDTH = 32
) (
    input  logic [ACC_WIDTH-1:0] a,
    input  logic [ACC_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 carry
);

    logic [ACC_WIDTH:0] full;

    assign full  = {1'b0, a} + {1'b0, b};
    assign carry = full[ACC_WIDTH];

`ifdef PRODUCT_ACC_SATURATE_EN
    // Once clamped, the accumulator sits at all-ones; any further non-zero
    // product carries again, so the clamp holds for the rest of the group.
    assign sum = carry ? {ACC_WIDTH{1'b1}} : full[ACC_WIDTH-1:0];
`else
    assign sum = full[ACC_WIDTH-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// product_accumulator: sums a stream of unsigned products over groups closed
// by in_last and presents the total, beat count and sticky overflow flag on
// a held output handshake.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high. The producer holds in_product/in_last while in_valid is
// high and in_ready is low; out_sum/out_count/out_overflow are held stable
// while out_valid is high until out_ready is seen high at a clock edge.
// in_ready depends only on state (and reset); out_valid only on state.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready     : product beat handshake
//   in_product, in_last   : 2*WORD_WIDTH-bit unsigned product, group close
//   out_valid/out_ready   : group result handshake
//   out_sum, out_count    : group total, beats in the group
//   out_overflow          : carry-out seen at least once in the group
//   debug_state           : current FSM state (acc_state_e encoding)
// Build option: PRODUCT_ACC_SATURATE_EN (clamp sum instead of wrap, in acc_adder).
module product_accumulator
    import acc_pkg::*;
#(
    parameter int WORD_WIDTH  = DEF_WORD_WIDTH,
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*WORD_WIDTH-1:0] in_product,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_WIDTH-1:0]    out_sum,
    output logic [COUNT_WIDTH-1:0]  out_count,
    output logic                    out_overflow,
    output logic [1:0]              debug_state
);

    acc_state_e             state, state_next;
    logic [ACC_WIDTH-1:0]   acc, acc_next;
    logic [COUNT_WIDTH-1:0] count, count_next;
    logic                   ovf, ovf_next;
    logic [ACC_WIDTH-1:0]   res_sum, res_sum_next;
    logic [COUNT_WIDTH-1:0] res_count, res_count_next;
    logic                   res_ovf, res_ovf_next;

    logic                   accept;
    logic [ACC_WIDTH-1:0]   product_ext;
    logic [ACC_WIDTH-1:0]   add_sum;
    logic                   add_carry;

    // acc/count/ovf are always zero in IDLE (cleared by reset and by the
    // output handshake), so the adder can take acc directly in both states.
    assign product_ext = ACC_WIDTH'(in_product);

    acc_adder #(.ACC_WIDTH(ACC_WIDTH)) u_adder (
        .a     (acc),
        .b     (product_ext),
        .sum   (add_sum),
        .carry (add_carry)
    );

    // Gating with reset keeps in_ready low during the reset cycle itself.
    assign in_ready     = !reset && (state != HOLD);
    assign accept       = in_valid && in_ready;
    assign out_valid    = (state == HOLD);
    assign out_sum      = res_sum;
    assign out_count    = res_count;
    assign out_overflow = res_ovf;
    assign debug_state  = state;

    always_comb begin
        state_next     = state;
        acc_next       = acc;
        count_next     = count;
        ovf_next       = ovf;
        res_sum_next   = res_sum;
        res_count_next = res_count;
        res_ovf_next   = res_ovf;
        case (state)
            IDLE, ACCUM: begin
                if (accept) begin
                    if (in_last) begin
                        res_sum_next   = add_sum;
                        res_count_next = count + COUNT_WIDTH'(1);
                        res_ovf_next   = ovf | add_carry;
                        state_next     = HOLD;
                    end else begin
                        acc_next       = add_sum;
                        count_next     = count + COUNT_WIDTH'(1);
                        ovf_next       = ovf | add_carry;
                        state_next     = ACCUM;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    acc_next   = '0;
                    count_next = '0;
                    ovf_next   = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            res_sum   <= '0;
            res_count <= '0;
            res_ovf   <= 1'b0;
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            count     <= count_next;
            ovf       <= ovf_next;
            res_sum   <= res_sum_next;
            res_count <= res_count_next;
            res_ovf   <= res_ovf_next;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed bench for product_accumulator.
// Table-driven groups on a 32-bit instance plus hand-written sequences for
// output stall, reset mid-group and 16-bit overflow (both build options).
module tb_product_accumulator;
    import acc_pkg::*;

    localparam int W = 49;   // {overflow, count[15:0], sum[31:0]}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- 32-bit instance ----------------
    logic        in_valid, in_ready, in_last, out_valid, out_ready, out_overflow;
    logic [15:0] in_product, out_count;
    logic [31:0] out_sum;
    logic [1:0]  debug_state;

    product_accumulator #(.WORD_WIDTH(8), .ACC_WIDTH(32), .COUNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_product(in_product), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count),
        .out_overflow(out_overflow), .debug_state(debug_state)
    );

    // ---------------- 16-bit accumulator instance ----------------
    logic        s_in_valid, s_in_ready, s_in_last, s_out_valid, s_out_ready, s_out_overflow;
    logic [15:0] s_in_product, s_out_count, s_out_sum;
    logic [1:0]  s_debug_state;

    product_accumulator #(.WORD_WIDTH(8), .ACC_WIDTH(16), .COUNT_WIDTH(16)) dut_small (
        .clk(clk), .reset(reset),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_product(s_in_product), .in_last(s_in_last),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_sum(s_out_sum), .out_count(s_out_count),
        .out_overflow(s_out_overflow), .debug_state(s_debug_state)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_result(input string name);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL %s: got empty expected queue expected an entry", name);
        end else begin
            e = exp_q.pop_front();
            check({name, " valid"}, 64'(out_valid), 64'd1);
            check({name, " sum"},   64'(out_sum),   64'(e[31:0]));
            check({name, " count"}, 64'(out_count), 64'(e[47:32]));
            check({name, " ovf"},   64'(out_overflow), 64'(e[48]));
        end
    endtask

    // ---------------- driver ----------------
    // Presents one beat and returns #1 after the edge where it was accepted.
    task automatic send_beat(input logic [15:0] p, input logic last);
        logic taken;
        taken      = 1'b0;
        in_valid   = 1'b1;
        in_product = p;
        in_last    = last;
        for (int i = 0; i < 20; i++) begin
            taken = in_ready;
            @(posedge clk);
            #1;
            if (taken) break;
        end
        in_valid = 1'b0;
        if (!taken) begin
            n_total++;
            n_bad++;
            $display("FAIL beat accept timeout: got in_ready=0 expected 1 within 20 cycles");
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          n;
        logic [15:0] beats [4];
        int          gap;
        logic [31:0] exp_sum;
        logic [15:0] exp_count;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [5];

    initial begin
        vecs[0] = '{n: 3, beats: '{16'd3, 16'd6, 16'd851, 16'd0}, gap: 0,
                    exp_sum: 32'd860, exp_count: 16'd3, exp_ovf: 1'b0};
        vecs[1] = '{n: 1, beats: '{16'd851, 16'd0, 16'd0, 16'd0}, gap: 0,
                    exp_sum: 32'd851, exp_count: 16'd1, exp_ovf: 1'b0};
        vecs[2] = '{n: 4, beats: '{16'd1, 16'd2, 16'd3, 16'd4}, gap: 1,
                    exp_sum: 32'd10, exp_count: 16'd4, exp_ovf: 1'b0};
        vecs[3] = '{n: 4, beats: '{16'hffff, 16'hffff, 16'hffff, 16'hffff}, gap: 0,
                    exp_sum: 32'd262140, exp_count: 16'd4, exp_ovf: 1'b0};
        vecs[4] = '{n: 2, beats: '{16'd0, 16'd0, 16'd0, 16'd0}, gap: 2,
                    exp_sum: 32'd0, exp_count: 16'd2, exp_ovf: 1'b0};

        reset = 1'b1;
        in_valid = 1'b0; in_product = '0; in_last = 1'b0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_in_product = '0; s_in_last = 1'b0; s_out_ready = 1'b1;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready",  64'(in_ready), 64'd0);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_sum",   64'(out_sum), 64'd0);
        check("reset out_count", 64'(out_count), 64'd0);
        check("reset out_ovf",   64'(out_overflow), 64'd0);
        check("reset state",     64'(debug_state), 64'(IDLE));
        reset = 1'b0;
        #1;
        check("in_ready after reset", 64'(in_ready), 64'd1);

        // ---- table-driven groups, out_ready held high ----
        for (int v = 0; v < 5; v++) begin
            out_ready = 1'b1;
            exp_q.push_back({vecs[v].exp_ovf, vecs[v].exp_count, vecs[v].exp_sum});
            for (int b = 0; b < vecs[v].n; b++) begin
                send_beat(vecs[v].beats[b], (b == vecs[v].n - 1));
                if (b != vecs[v].n - 1 && vecs[v].gap > 0) begin
                    repeat (vecs[v].gap) begin
                        @(posedge clk);
                        #1;
                    end
                end
            end
            // out_valid must already be high the cycle after the last beat.
            check_result($sformatf("vec%0d", v));
            check($sformatf("vec%0d in_ready hold", v), 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d out_valid drop", v), 64'(out_valid), 64'd0);
            check($sformatf("vec%0d in_ready back", v), 64'(in_ready), 64'd1);
        end

        // ---- output stall: HOLD with out_ready low for 5 cycles ----
        out_ready = 1'b0;
        exp_q.push_back({1'b0, 16'd2, 32'd12});
        send_beat(16'd7, 1'b0);
        send_beat(16'd5, 1'b1);
        check_result("stall");
        in_valid = 1'b1; in_product = 16'd99; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("stall%0d valid", i), 64'(out_valid), 64'd1);
            check($sformatf("stall%0d sum", i),   64'(out_sum), 64'd12);
            check($sformatf("stall%0d count", i), 64'(out_count), 64'd2);
            check($sformatf("stall%0d in_ready", i), 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("stall release valid", 64'(out_valid), 64'd0);
        check("stall release state", 64'(debug_state), 64'(IDLE));
        exp_q.push_back({1'b0, 16'd1, 32'd4});
        send_beat(16'd4, 1'b1);
        check_result("after stall");
        @(posedge clk);
        #1;

        // ---- reset mid-group ----
        send_beat(16'd10, 1'b0);
        send_beat(16'd20, 1'b0);
        reset = 1'b1;
        #1;
        check("midreset in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        check("midreset out_valid", 64'(out_valid), 64'd0);
        check("midreset state", 64'(debug_state), 64'(IDLE));
        reset = 1'b0;
        exp_q.push_back({1'b0, 16'd1, 32'd5});
        send_beat(16'd5, 1'b1);
        check_result("after reset");
        @(posedge clk);
        #1;

        // ---- 16-bit accumulator overflow ----
        s_in_valid = 1'b1; s_in_product = 16'd65000; s_in_last = 1'b0;
        check("small in_ready", 64'(s_in_ready), 64'd1);
        @(posedge clk);
        #1;
        s_in_product = 16'd1000; s_in_last = 1'b1;
        check("small in_ready 2", 64'(s_in_ready), 64'd1);
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        check("small valid", 64'(s_out_valid), 64'd1);
`ifdef PRODUCT_ACC_SATURATE_EN
        check("small sum", 64'(s_out_sum), 64'd65535);
`else
        check("small sum", 64'(s_out_sum), 64'd464);
`endif
        check("small count", 64'(s_out_count), 64'd2);
        check("small ovf",   64'(s_out_overflow), 64'd1);
        @(posedge clk);
        #1;
        check("small valid drop", 64'(s_out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
